// File: rtl/rom_read_sequencer.sv
// Burst reader for the lab ROM: issues consecutive (wrapping) addresses and
// streams the returned words through a small FIFO with valid/ready flow control.
module rom_read_sequencer #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int LW = ADDR_W + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] base_r;
  logic [LW-1:0]     len_r;
  logic [LW-1:0]     issued_r;
  logic [ADDR_W-1:0] rom_address_r;
  logic              s1_vld_r, s1_last_r, s2_vld_r, s2_last_r;
  logic              busy_r, done_r;

  logic [DATA_W-1:0] mem_data_r [FIFO_DEPTH];
  logic              mem_last_r [FIFO_DEPTH];
  logic [PW-1:0]     wptr_r, rptr_r;
  logic [CW-1:0]     count_r;

  logic [1:0]        inflight_s;
  logic [CW-1:0]     occ_s;
  logic              accept_s, issue_s, issue_last_s, done_set_s;
  logic [ADDR_W-1:0] issue_addr_s;
  logic              push_s, pop_s, final_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign inflight_s  = {1'b0, s1_vld_r} + {1'b0, s2_vld_r};
  assign occ_s       = count_r + CW'(inflight_s);
  assign out_valid   = (count_r != {CW{1'b0}});
  assign out_data    = mem_data_r[rptr_r];
  assign out_last    = mem_last_r[rptr_r];
  assign push_s      = s2_vld_r;
  assign pop_s       = out_valid && out_ready;
  assign final_pop_s = pop_s && mem_last_r[rptr_r];

  assign rom_address = rom_address_r;
  assign busy        = busy_r;
  assign done        = done_r;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_next_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = issue_last_s ? ST_DRAIN : ST_RUN;
        else          state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (issue_s && issue_last_s) state_next_s = ST_DRAIN;
        else                         state_next_s = ST_RUN;
      end
      ST_DRAIN: begin
        // The tagged last beat is the final word of the burst, so popping it drains everything
        if (final_pop_s && (inflight_s == 2'd0)) state_next_s = ST_IDLE;
        else                                     state_next_s = ST_DRAIN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Issue decisions; the first address goes out on the accepting edge itself
  always_comb begin
    accept_s     = (state_r == ST_IDLE) && start && (len != {LW{1'b0}});
    issue_s      = 1'b0;
    issue_addr_s = base_r + issued_r[ADDR_W-1:0];
    issue_last_s = (issued_r == (len_r - LW'(1)));
    if (accept_s) begin
      issue_s      = 1'b1;
      issue_addr_s = base_addr;
      issue_last_s = (len == LW'(1));
    end else if (state_r == ST_RUN) begin
      issue_s = (occ_s < CW'(FIFO_DEPTH));
    end else begin
      issue_s = 1'b0;
    end
    done_set_s = (state_r == ST_DRAIN) && (state_next_s == ST_IDLE);
  end

  // Command latch, address issue and the two-stage read tag pipeline
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_r        <= {ADDR_W{1'b0}};
      len_r         <= {LW{1'b0}};
      issued_r      <= {LW{1'b0}};
      rom_address_r <= {ADDR_W{1'b0}};
      s1_vld_r      <= 1'b0;
      s1_last_r     <= 1'b0;
      s2_vld_r      <= 1'b0;
      s2_last_r     <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      if (accept_s) begin
        base_r   <= base_addr;
        len_r    <= len;
        issued_r <= LW'(1);
      end else if (issue_s) begin
        issued_r <= issued_r + LW'(1);
      end
      if (issue_s) rom_address_r <= issue_addr_s;
      s1_vld_r  <= issue_s;
      s1_last_r <= issue_s && issue_last_s;
      s2_vld_r  <= s1_vld_r;
      s2_last_r <= s1_last_r;
      busy_r    <= (state_next_s != ST_IDLE);
      done_r    <= done_set_s;
    end
  end

  // Capture FIFO; issue throttling guarantees a free slot for every push
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_r[i] <= {DATA_W{1'b0}};
        mem_last_r[i] <= 1'b0;
      end
    end else begin
      if (push_s) begin
        mem_data_r[wptr_r] <= rom_q;
        mem_last_r[wptr_r] <= s2_last_r;
        wptr_r             <= ptr_inc(wptr_r);
      end
      if (pop_s) rptr_r <= ptr_inc(rptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
